// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access-size codes, FSM states
// and the byte-offset to byte-lane mapping used by both endianness modes.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Lane 3 holds word bits [31:24]; big-endian puts byte offset 0 there.
  function automatic logic [1:0] lane_of(input logic [1:0] offset, input logic big_endian);
    logic [1:0] lane;
    if (big_endian) begin
      lane = 2'd3 - offset;
    end else begin
      lane = offset;
    end
    return lane;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: turns size/offset into byte enables and
// lane-positioned store data, and pulls a byte/half/word out of a read word
// with sign or zero extension.
module mem_lane_align
  import dmem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [1:0]  byte_lane_s;
  logic [4:0]  byte_shift_s;
  logic [7:0]  rbyte_s;
  logic        half_upper_s;
  logic [15:0] rhalf_s;

  assign byte_lane_s  = lane_of(offset, BIG_ENDIAN);
  assign byte_shift_s = {byte_lane_s, 3'b000};
  assign rbyte_s      = rword[byte_shift_s +: 8];

  // A half at offset 0 sits in the upper 16 bits for big-endian, lower for little-endian.
  assign half_upper_s = BIG_ENDIAN ? ~offset[1] : offset[1];
  assign rhalf_s      = half_upper_s ? rword[31:16] : rword[15:0];

  // Per-size enables, store positioning and load extension.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'd0;
    rdata_ext   = 32'd0;
    case (size)
      SIZE_BYTE: begin
        byte_en     = 4'b0001 << byte_lane_s;
        wdata_lanes = {24'd0, wdata[7:0]} << byte_shift_s;
        if (is_unsigned) begin
          rdata_ext = {24'd0, rbyte_s};
        end else begin
          rdata_ext = {{24{rbyte_s[7]}}, rbyte_s};
        end
      end
      SIZE_HALF: begin
        if (half_upper_s) begin
          byte_en     = 4'b1100;
          wdata_lanes = {wdata[15:0], 16'd0};
        end else begin
          byte_en     = 4'b0011;
          wdata_lanes = {16'd0, wdata[15:0]};
        end
        if (is_unsigned) begin
          rdata_ext = {16'd0, rhalf_s};
        end else begin
          rdata_ext = {{16{rhalf_s[15]}}, rhalf_s};
        end
      end
      SIZE_WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'd0;
        rdata_ext   = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with byte/half/word accesses behind a
// valid/ready request and a one-cycle response strobe after LATENCY cycles.
// Misaligned, out-of-range and illegal-size accesses fault without side effects.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 1,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int         DEPTH        = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD     = 4'(LATENCY - 1);
  localparam logic       SINGLE_CYCLE = (LATENCY == 1) ? 1'b1 : 1'b0;

  logic [7:0]  mem_r [DEPTH];

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_fault_r;

  logic        write_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        op_write_s;
  logic [1:0]  op_size_s;
  logic        op_unsigned_s;
  logic [31:0] op_addr_s;
  logic [31:0] op_wdata_s;

  logic        accept_s;
  logic        enter_resp_s;
  logic        misaligned_s;
  logic        out_of_range_s;
  logic        fault_s;
  logic        commit_s;
  logic [ADDR_WIDTH-1:0] word_base_s;
  logic [7:0]  rbyte_s [4];
  logic [31:0] rword_s;
  logic [3:0]  byte_en_s;
  logic [31:0] wdata_lanes_s;
  logic [31:0] rdata_ext_s;
  logic [31:0] load_data_s;

  assign accept_s   = req_valid & req_ready_r;
  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_fault = resp_fault_r;

  // With LATENCY=1 the access completes on the accept edge, so it works from the live request.
  always_comb begin
    if (state_r == ST_IDLE) begin
      op_write_s    = req_write;
      op_size_s     = req_size;
      op_unsigned_s = req_unsigned;
      op_addr_s     = req_addr;
      op_wdata_s    = req_wdata;
    end else begin
      op_write_s    = write_r;
      op_size_s     = size_r;
      op_unsigned_s = unsigned_r;
      op_addr_s     = addr_r;
      op_wdata_s    = wdata_r;
    end
  end

  // Alignment check for the access in flight.
  always_comb begin
    misaligned_s = 1'b0;
    case (op_size_s)
      SIZE_HALF: misaligned_s = op_addr_s[0];
      SIZE_WORD: misaligned_s = |op_addr_s[1:0];
      default:   misaligned_s = 1'b0;
    endcase
  end

  // No wrap-around: any address bit above the array depth is a fault.
  assign out_of_range_s = (op_addr_s >> ADDR_WIDTH) != 32'd0;
  assign fault_s        = misaligned_s | out_of_range_s | (op_size_s == SIZE_ILL);

  // The edge entering RESP is where stores commit and loads sample.
  always_comb begin
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: enter_resp_s = accept_s & SINGLE_CYCLE;
      ST_WAIT: enter_resp_s = (cnt_r == 4'd1);
      default: enter_resp_s = 1'b0;
    endcase
  end

  assign commit_s    = enter_resp_s & op_write_s & ~fault_s;
  assign word_base_s = {op_addr_s[ADDR_WIDTH-1:2], 2'b00};

  // Gather the four bytes of the addressed word, ordered by offset.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rbyte_s[k] = mem_r[word_base_s | ADDR_WIDTH'(k)];
    end
  end

  assign rword_s = BIG_ENDIAN ? {rbyte_s[0], rbyte_s[1], rbyte_s[2], rbyte_s[3]}
                              : {rbyte_s[3], rbyte_s[2], rbyte_s[1], rbyte_s[0]};

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_align (
    .size        (op_size_s),
    .offset      (op_addr_s[1:0]),
    .is_unsigned (op_unsigned_s),
    .wdata       (op_wdata_s),
    .rword       (rword_s),
    .byte_en     (byte_en_s),
    .wdata_lanes (wdata_lanes_s),
    .rdata_ext   (rdata_ext_s)
  );

  // Stores and faults return zero data.
  always_comb begin
    if (op_write_s || fault_s) begin
      load_data_s = 32'd0;
    end else begin
      load_data_s = rdata_ext_s;
    end
  end

  // Byte array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en_s[lane_of(2'(k), BIG_ENDIAN)]) begin
          mem_r[word_base_s | ADDR_WIDTH'(k)] <= wdata_lanes_s[{lane_of(2'(k), BIG_ENDIAN), 3'b000} +: 8];
        end
      end
    end
  end

  // Request FSM, latency counter, request capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_fault_r <= 1'b0;
      write_r      <= 1'b0;
      size_r       <= SIZE_BYTE;
      unsigned_r   <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_fault_r <= 1'b0;
          if (accept_s) begin
            write_r     <= req_write;
            size_r      <= req_size;
            unsigned_r  <= req_unsigned;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            if (enter_resp_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= load_data_s;
              resp_fault_r <= fault_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (enter_resp_s) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= load_data_s;
            resp_fault_r <= fault_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_fault_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_fault_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
